// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the 2-read/1-write register file.
package reg_file_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks every entry once, one zero-write per cycle.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          clr_req,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we,
  output logic          busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (state == IDLE) begin
        if (clr_req) begin
          state <= CLEAR;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      end else begin
        // Final entry is being zeroed on this edge; done pulses next cycle.
        if (cnt == LAST) begin
          state    <= IDLE;
          busy     <= 1'b0;
          clr_done <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_2r1w.sv
// Byte-strobed register file with two registered read ports and a bulk clear.
// Define RF_BYPASS_EN to forward same-cycle write data to a matching read.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = WIDTH / 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [NB-1:0]    WrStrb,
  input  logic             RdEnA,
  input  logic [AW-1:0]    RdAddrA,
  input  logic             RdEnB,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataA,
  output logic [WIDTH-1:0] RdDataB,
  output logic             RdValidA,
  output logic             RdValidB,
  input  logic             ClrReq,
  output logic             Busy,
  output logic             ClrDone,
  output logic             AddrErr
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [NB-1:0]    strb);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++)
      if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    clr_addr;
  logic             clr_we;
  logic             idle_ok, wr_ok, rd_a_go, rd_b_go, err_p0;
  logic [WIDTH-1:0] word_a_p0, word_b_p0;
  logic [WIDTH-1:0] rd_data_a_p1, rd_data_b_p1;
  logic             vld_a_p1, vld_b_p1, err_p1;

  rf_clear_seq #(.DEPTH(DEPTH)) u_clear (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .clr_req  (ClrReq),
    .clr_addr (clr_addr),
    .clr_we   (clr_we),
    .busy     (Busy),
    .clr_done (ClrDone)
  );

  // A clear request in the same cycle wins over any access.
  assign idle_ok = !Busy && !ClrReq;
  assign wr_ok   = WrEn && idle_ok && in_range(WrAddr);
  assign rd_a_go = RdEnA && idle_ok;
  assign rd_b_go = RdEnB && idle_ok;
  assign err_p0  = idle_ok && ((WrEn  && !in_range(WrAddr))  ||
                               (RdEnA && !in_range(RdAddrA)) ||
                               (RdEnB && !in_range(RdAddrB)));

  // Stage p0: array lookup; out-of-range addresses match nothing and read 0.
  always_comb begin
    word_a_p0 = '0;
    word_b_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddrA == i[AW-1:0]) word_a_p0 = mem[i];
      if (RdAddrB == i[AW-1:0]) word_b_p0 = mem[i];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (WrAddr == RdAddrA)) word_a_p0 = merge_bytes(word_a_p0, WrData, WrStrb);
    if (wr_ok && (WrAddr == RdAddrB)) word_b_p0 = merge_bytes(word_b_p0, WrData, WrStrb);
`endif
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_we && (clr_addr == i[AW-1:0]))
          mem[i] <= '0;
        else if (wr_ok && (WrAddr == i[AW-1:0]))
          mem[i] <= merge_bytes(mem[i], WrData, WrStrb);
      end
    end
  end

  // Stage p1: registered read data, valids and address-error pulse.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rd_data_a_p1 <= '0;
      rd_data_b_p1 <= '0;
      vld_a_p1     <= 1'b0;
      vld_b_p1     <= 1'b0;
      err_p1       <= 1'b0;
    end else begin
      vld_a_p1 <= rd_a_go;
      vld_b_p1 <= rd_b_go;
      err_p1   <= err_p0;
      if (rd_a_go) rd_data_a_p1 <= word_a_p0;
      if (rd_b_go) rd_data_b_p1 <= word_b_p0;
    end
  end

  assign RdDataA  = rd_data_a_p1;
  assign RdDataB  = rd_data_b_p1;
  assign RdValidA = vld_a_p1;
  assign RdValidB = vld_b_p1;
  assign AddrErr  = err_p1;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: DEPTH=8 main instance, DEPTH=6 for address errors.
module tb_reg_file_2r1w;

  logic CLK = 1'b0;
  logic RST_n;
  always #5 CLK = ~CLK;

  logic        wr_en, rd_en_a, rd_en_b, clr_req;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data, rd_data_a, rd_data_b;
  logic [1:0]  wr_strb;
  logic        rd_vld_a, rd_vld_b, busy, clr_done, addr_err;

  logic        wr_en2, rd_en_a2, rd_en_b2, clr_req2;
  logic [2:0]  wr_addr2, rd_addr_a2, rd_addr_b2;
  logic [15:0] wr_data2, rd_data_a2, rd_data_b2;
  logic [1:0]  wr_strb2;
  logic        rd_vld_a2, rd_vld_b2, busy2, clr_done2, addr_err2;

  int errs = 0;
  int checks = 0;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .WrStrb(wr_strb), .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdEnB(rd_en_b),
    .RdAddrB(rd_addr_b), .RdDataA(rd_data_a), .RdDataB(rd_data_b),
    .RdValidA(rd_vld_a), .RdValidB(rd_vld_b), .ClrReq(clr_req), .Busy(busy),
    .ClrDone(clr_done), .AddrErr(addr_err)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6)) dut6 (
    .CLK(CLK), .RST_n(RST_n), .WrEn(wr_en2), .WrAddr(wr_addr2), .WrData(wr_data2),
    .WrStrb(wr_strb2), .RdEnA(rd_en_a2), .RdAddrA(rd_addr_a2), .RdEnB(rd_en_b2),
    .RdAddrB(rd_addr_b2), .RdDataA(rd_data_a2), .RdDataB(rd_data_b2),
    .RdValidA(rd_vld_a2), .RdValidB(rd_vld_b2), .ClrReq(clr_req2), .Busy(busy2),
    .ClrDone(clr_done2), .AddrErr(addr_err2)
  );

  task automatic write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
    @(negedge CLK);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic read_a(input logic [2:0] a, output logic [15:0] d, output logic v);
    @(negedge CLK);
    rd_en_a = 1'b1; rd_addr_a = a;
    @(negedge CLK);
    rd_en_a = 1'b0;
    d = rd_data_a; v = rd_vld_a;
  endtask

  task automatic read_b(input logic [2:0] a, output logic [15:0] d, output logic v);
    @(negedge CLK);
    rd_en_b = 1'b1; rd_addr_b = a;
    @(negedge CLK);
    rd_en_b = 1'b0;
    d = rd_data_b; v = rd_vld_b;
  endtask

  task automatic test_reset;
    logic [15:0] d; logic v;
    RST_n = 1'b1;
    #3 RST_n = 1'b0;
    #1;
    checks++;
    if ({rd_data_a, rd_data_b} !== 32'h0) begin
      errs++; $display("FAIL reset_rddata: got %h required 0", {rd_data_a, rd_data_b});
    end
    checks++;
    if ({rd_vld_a, rd_vld_b, busy, clr_done, addr_err} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b required 00000",
                       {rd_vld_a, rd_vld_b, busy, clr_done, addr_err});
    end
    repeat (2) @(negedge CLK);
    // Write issued at the release point must land on the very first edge.
    RST_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444; wr_strb = 2'b11;
    @(negedge CLK);
    wr_en = 1'b0;
    read_a(3'd4, d, v);
    checks++;
    if (d !== 16'h4444) begin
      errs++; $display("FAIL first_edge_write: got %h required 4444", d);
    end
  endtask

  task automatic test_basic;
    logic [15:0] d; logic v;
    write(3'd3, 16'hBEEF, 2'b11);
    read_a(3'd3, d, v);
    checks++;
    if (d !== 16'hBEEF || v !== 1'b1) begin
      errs++; $display("FAIL basic_read: got %h/%b required beef/1", d, v);
    end
    @(negedge CLK);
    checks++;
    if (rd_data_a !== 16'hBEEF || rd_vld_a !== 1'b0) begin
      errs++; $display("FAIL hold_idle: got %h/%b required beef/0", rd_data_a, rd_vld_a);
    end
  endtask

  task automatic test_strobe;
    logic [15:0] d; logic v;
    write(3'd5, 16'h1234, 2'b11);
    write(3'd5, 16'hABCD, 2'b10);
    read_b(3'd5, d, v);
    checks++;
    if (d !== 16'hAB34 || v !== 1'b1) begin
      errs++; $display("FAIL byte_strobe: got %h/%b required ab34/1", d, v);
    end
  endtask

  task automatic test_dual_read;
    @(negedge CLK);
    rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd5;
    @(negedge CLK);
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    checks++;
    if (rd_data_a !== 16'hAB34 || rd_data_b !== 16'hAB34 || !rd_vld_a || !rd_vld_b) begin
      errs++; $display("FAIL dual_same_addr: got %h/%h required ab34/ab34", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_rw_diff;
    logic [15:0] d; logic v;
    @(negedge CLK);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555; wr_strb = 2'b11;
    rd_en_a = 1'b1; rd_addr_a = 3'd3;
    @(negedge CLK);
    wr_en = 1'b0; rd_en_a = 1'b0;
    checks++;
    if (rd_data_a !== 16'hBEEF || rd_vld_a !== 1'b1) begin
      errs++; $display("FAIL rw_diff_read: got %h/%b required beef/1", rd_data_a, rd_vld_a);
    end
    read_b(3'd1, d, v);
    checks++;
    if (d !== 16'h5555) begin
      errs++; $display("FAIL rw_diff_write: got %h required 5555", d);
    end
  endtask

  task automatic test_collision;
    logic [15:0] d, exp; logic v;
`ifdef RF_BYPASS_EN
    exp = 16'h00FF;
`else
    exp = 16'h0001;
`endif
    write(3'd2, 16'h0001, 2'b11);
    @(negedge CLK);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00FF; wr_strb = 2'b11;
    rd_en_b = 1'b1; rd_addr_b = 3'd2;
    @(negedge CLK);
    wr_en = 1'b0; rd_en_b = 1'b0;
    checks++;
    if (rd_data_b !== exp) begin
      errs++; $display("FAIL collision_read: got %h required %h", rd_data_b, exp);
    end
    read_b(3'd2, d, v);
    checks++;
    if (d !== 16'h00FF) begin
      errs++; $display("FAIL collision_store: got %h required 00ff", d);
    end
  endtask

  task automatic test_clear;
    logic [15:0] d; logic v;
    int busy_n, done_n, side_n;
    busy_n = 0; done_n = 0; side_n = 0;
    for (int i = 0; i < 8; i++) write(3'(i), 16'(16'h1111 * (i + 1)), 2'b11);
    @(negedge CLK);
    clr_req = 1'b1; rd_en_a = 1'b1; rd_addr_a = 3'd3;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hDEAD; wr_strb = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      clr_req = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0;
      if (busy) busy_n++;
      if (clr_done) done_n++;
      if (rd_vld_a || rd_vld_b || addr_err) side_n++;
      if (c == 3) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; wr_strb = 2'b11;
        rd_en_a = 1'b1; rd_en_b = 1'b1; clr_req = 1'b1;
      end
    end
    checks++;
    if (busy_n != 8) begin
      errs++; $display("FAIL clear_busy_cycles: got %0d required 8", busy_n);
    end
    checks++;
    if (done_n != 1) begin
      errs++; $display("FAIL clear_done_pulses: got %0d required 1", done_n);
    end
    checks++;
    if (side_n != 0) begin
      errs++; $display("FAIL clear_side_pulses: got %0d required 0", side_n);
    end
    for (int i = 0; i < 8; i++) begin
      read_a(3'(i), d, v);
      checks++;
      if (d !== 16'h0 || v !== 1'b1) begin
        errs++; $display("FAIL clear_entry%0d: got %h/%b required 0000/1", i, d, v);
      end
    end
  endtask

  task automatic test_addr_err;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      wr_en2 = 1'b1; wr_addr2 = 3'(i); wr_data2 = 16'(16'h1100 + i); wr_strb2 = 2'b11;
    end
    @(negedge CLK);
    wr_en2 = 1'b1; wr_addr2 = 3'd7; wr_data2 = 16'hFFFF; wr_strb2 = 2'b11;
    @(negedge CLK);
    wr_en2 = 1'b0;
    checks++;
    if (addr_err2 !== 1'b1) begin
      errs++; $display("FAIL err_on_write: got %b required 1", addr_err2);
    end
    rd_en_a2 = 1'b1; rd_addr_a2 = 3'd0;
    @(negedge CLK);
    checks++;
    if (addr_err2 !== 1'b0 || rd_data_a2 !== 16'h1100) begin
      errs++; $display("FAIL err_clean_read: got %b/%h required 0/1100", addr_err2, rd_data_a2);
    end
    rd_addr_a2 = 3'd7;
    @(negedge CLK);
    rd_en_a2 = 1'b0;
    checks++;
    if (addr_err2 !== 1'b1 || rd_vld_a2 !== 1'b1 || rd_data_a2 !== 16'h0) begin
      errs++; $display("FAIL err_on_read: got %b/%b/%h required 1/1/0000",
                       addr_err2, rd_vld_a2, rd_data_a2);
    end
    for (int i = 0; i < 6; i++) begin
      rd_en_a2 = 1'b1; rd_addr_a2 = 3'(i);
      @(negedge CLK);
      checks++;
      if (rd_data_a2 !== 16'(16'h1100 + i) || addr_err2 !== 1'b0) begin
        errs++; $display("FAIL err_entry%0d: got %h/%b required %h/0",
                         i, rd_data_a2, addr_err2, 16'(16'h1100 + i));
      end
    end
    rd_en_a2 = 1'b0;
  endtask

  task automatic test_reset_in_clear;
    logic [15:0] d; logic v;
    int seen;
    seen = 0;
    write(3'd6, 16'h6666, 2'b11);
    write(3'd7, 16'h7777, 2'b11);
    read_a(3'd7, d, v);
    checks++;
    if (d !== 16'h7777) begin
      errs++; $display("FAIL pre_clear_read: got %h required 7777", d);
    end
    @(negedge CLK);
    clr_req = 1'b1;
    @(negedge CLK);
    clr_req = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL clear4_busy: got %b required 1", busy);
    end
    #1 RST_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || rd_data_a !== 16'h0) begin
      errs++; $display("FAIL reset_abort: got %b/%b/%h required 0/0/0000",
                       busy, clr_done, rd_data_a);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      if (busy || clr_done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++; $display("FAIL abort_no_resume: got %0d busy/done cycles required 0", seen);
    end
    for (int i = 6; i < 8; i++) begin
      read_a(3'(i), d, v);
      checks++;
      if (d !== 16'h0) begin
        errs++; $display("FAIL abort_entry%0d: got %h required 0000", i, d);
      end
    end
  endtask

  initial begin
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
    rd_en_a = 0; rd_en_b = 0; rd_addr_a = 0; rd_addr_b = 0; clr_req = 0;
    wr_en2 = 0; wr_addr2 = 0; wr_data2 = 0; wr_strb2 = 0;
    rd_en_a2 = 0; rd_en_b2 = 0; rd_addr_a2 = 0; rd_addr_b2 = 0; clr_req2 = 0;
    test_reset;
    test_basic;
    test_strobe;
    test_dual_read;
    test_rw_diff;
    test_collision;
    test_clear;
    test_addr_err;
    test_reset_in_clear;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; legal values are 2 to 256, not required to be a power of two.
REQ-003 SHALL have localparam AW = $clog2(DEPTH), address width.
REQ-004 SHALL have CLK  input  1  clock, with all state updating on the rising edge.
REQ-005 SHALL have RST_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have WrEn  input  1  write request.
REQ-007 SHALL have WrAddr  input  AW  write address.
REQ-008 SHALL have WrData  input  WIDTH  write data.
REQ-009 SHALL have WrStrb  input  WIDTH/8  byte enables; bit k enables byte k.
REQ-010 SHALL have RdEnA/RdEnB  input  1  read requests for port A and port B.
REQ-011 SHALL have RdAddrA/RdAddrB  input  AW  read addresses for port A and port B.
REQ-012 SHALL have RdDataA/RdDataB  output  WIDTH  registered read data.
REQ-013 SHALL have RdValidA/RdValidB  output  1  one-cycle pulse qualifying RdDataA/RdDataB.
REQ-014 SHALL have ClrReq  input  1  request to bulk-clear the whole array.
REQ-015 SHALL have Busy  output  1  high while a clear sequence runs.
REQ-016 SHALL have ClrDone  output  1  one-cycle pulse when a clear completes.
REQ-017 SHALL have AddrErr  output  1  one-cycle pulse on any access to an address >= DEPTH.

Function
REQ-018 SHALL, when WrEn=1 and Busy=0 at a rising edge, write each byte k of entry WrAddr with WrData byte k for which WrStrb[k]=1; bytes with WrStrb[k]=0 SHALL keep their value.
REQ-019 SHALL, for each port independently, when RdEn=1 and Busy=0, register mem[RdAddr] into RdData and assert RdValid for exactly the following cycle (1-cycle latency).
REQ-020 SHALL hold RdData unchanged when no read occurs; RdValid SHALL be 0 in that cycle.
REQ-021 SHALL, when both ports read the same address in the same cycle, return identical data on both ports.
REQ-022 SHALL process a simultaneous read and write to different addresses fully, with no interaction between them.
REQ-023 SHALL ignore a write to an address >= DEPTH; a read of an address >= DEPTH SHALL return 0 with RdValid=1; either case SHALL pulse AddrErr in the next cycle.
REQ-024 SHALL implement a two-state FSM: IDLE -> CLEAR on ClrReq=1; in CLEAR, write 0 to one entry per cycle with a counter running from 0 to DEPTH-1; CLEAR -> IDLE after entry DEPTH-1 is written.
REQ-025 SHALL drive Busy=1 in every CLEAR cycle, and SHALL pulse ClrDone in the cycle after the final entry is cleared; a clear therefore takes exactly DEPTH cycles.
REQ-026 SHALL, while Busy=1, ignore WrEn, RdEnA, RdEnB and ClrReq, with no RdValid and no AddrErr pulses.
REQ-027 SHALL give ClrReq priority over a WrEn or RdEn presented in the same cycle while in IDLE; that access is dropped.

Reset
REQ-028 SHALL, on RST_n=0, immediately zero every memory entry, set RdDataA/B to 0, set RdValidA/B, AddrErr, Busy and ClrDone to 0, set the FSM to IDLE and set the clear counter to 0.
REQ-029 SHALL, on reset assertion during CLEAR, abort the sequence without a ClrDone pulse, and then require a new ClrReq to start another clear.
REQ-030 SHALL accept requests on the first rising edge after RST_n deasserts.

Configuration
REQ-031 SHALL, with RF_BYPASS_EN defined, forward write data to a same-cycle read of the same address: RdData is the stored word with the strobed bytes replaced by WrData.
REQ-032 SHALL, without RF_BYPASS_EN, return the pre-write contents for a same-cycle read and write of the same address.

Structure
REQ-033 SHALL place the FSM state typedef (IDLE, CLEAR) and the default WIDTH/DEPTH constants in package reg_file_pkg.
REQ-034 SHALL implement the clear FSM and counter as a sub-module rf_clear_seq, which outputs the clear address, the clear-write strobe, Busy and ClrDone.

Verification
REQ-035 SHALL test a basic write and read: write 0xBEEF to addr 3 with WrStrb=2'b11, then RdEnA at addr 3 -> next cycle RdDataA=0xBEEF and RdValidA=1.
REQ-036 SHALL test byte strobes: addr 5 holds 0x1234, then write 0xABCD with WrStrb=2'b10 -> a read returns 0xAB34.
REQ-037 SHALL test a same-address collision: addr 2 holds 0x0001, then write 0x00FF with a same-cycle RdEnB at addr 2 -> RdDataB=0x00FF with RF_BYPASS_EN, and 0x0001 without it.
REQ-038 SHALL test a clear: fill all 8 entries, pulse ClrReq -> Busy high for 8 cycles, a WrEn during Busy is ignored, ClrDone pulses once, and all reads return 0.
REQ-039 SHALL test an address error with DEPTH=6: write to addr 7, then read addr 7 -> AddrErr pulses twice, RdDataA=0, and no entry is modified.
REQ-040 SHALL test reset during a clear: assert RST_n=0 in the fourth CLEAR cycle -> Busy=0 immediately, no ClrDone pulse, and all entries read 0.
